// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS datapath.
// master = controller, slave = datapath.
interface multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        zero;
    logic        pc_write;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        mem2reg;
    logic        reg_dst;
    logic        reg_write;
    logic        ex_top;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  pc_src;
    logic        trap;
    logic [3:0]  state;
    logic [31:0] instr_count;

    modport master (
        input  opcode, func, zero,
        output pc_write, ir_write, iord, mem_read, mem_write,
        output mem2reg, reg_dst, reg_write, ex_top,
        output alu_src_a, alu_src_b, alu_op, pc_src,
        output trap, state, instr_count
    );

    modport slave (
        output opcode, func, zero,
        input  pc_write, ir_write, iord, mem_read, mem_write,
        input  mem2reg, reg_dst, reg_write, ex_top,
        input  alu_src_a, alu_src_b, alu_op, pc_src,
        input  trap, state, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the multicycle MIPS datapath,
// with a retired-instruction counter and a trap on bad encodings.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [3:0] ADD_OP = 4'b0010;
    localparam logic [3:0] SUB_OP = 4'b0110;
    localparam logic [3:0] AND_OP = 4'b0000;
    localparam logic [3:0] OR_OP  = 4'b0001;
    localparam logic [3:0] SLT_OP = 4'b0111;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        retire;
    logic        func_ok;
    logic [3:0]  func_alu;

    logic        pcw_raw, irw_raw, mr_raw, mw_raw, rw_raw;
    logic        iord, m2r, rdst, src_a, trap;
    logic [1:0]  src_b, pc_src;
    logic [3:0]  alu_op;

    // R-type function decode shared by DECODE (legality) and EXEC (ALU op)
    always_comb begin
        func_ok  = 1'b1;
        func_alu = ADD_OP;
        case (bus.func)
            FN_ADD:  func_alu = ADD_OP;
            FN_SUB:  func_alu = SUB_OP;
            FN_AND:  func_alu = AND_OP;
            FN_OR:   func_alu = OR_OP;
            FN_SLT:  func_alu = SLT_OP;
            default: func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OPC_RTYPE:      state_d = func_ok ? S_EXEC : S_TRAP;
                    OPC_LW, OPC_SW: state_d = S_MEMADR;
                    OPC_BEQ:        state_d = S_BRANCH;
                    OPC_ADDI:       state_d = S_ADDIEX;
                    OPC_J:          state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                state_d = (bus.opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RTWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (state_q)
            S_MEMWB, S_MEMWR, S_RTWB,
            S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
            default:                    retire = 1'b0;
        endcase
    end

    assign cnt_d = retire ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pcw_raw = 1'b0;
        irw_raw = 1'b0;
        mr_raw  = 1'b0;
        mw_raw  = 1'b0;
        rw_raw  = 1'b0;
        iord    = 1'b0;
        m2r     = 1'b0;
        rdst    = 1'b0;
        src_a   = 1'b0;
        src_b   = 2'b00;
        alu_op  = AND_OP;
        pc_src  = 2'b00;
        trap    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mr_raw  = 1'b1;
                irw_raw = 1'b1;
                src_b   = 2'b01;
                alu_op  = ADD_OP;
                pcw_raw = 1'b1;
            end
            S_DECODE: begin
                src_b  = 2'b11;
                alu_op = ADD_OP;
            end
            S_MEMADR, S_ADDIEX: begin
                src_a  = 1'b1;
                src_b  = 2'b10;
                alu_op = ADD_OP;
            end
            S_MEMRD: begin
                mr_raw = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                rw_raw = 1'b1;
                m2r    = 1'b1;
            end
            S_MEMWR: begin
                mw_raw = 1'b1;
                iord   = 1'b1;
            end
            S_EXEC: begin
                src_a  = 1'b1;
                alu_op = func_alu;
            end
            S_RTWB: begin
                rw_raw = 1'b1;
                rdst   = 1'b1;
            end
            // Only output that is not a pure function of state
            S_BRANCH: begin
                src_a   = 1'b1;
                alu_op  = SUB_OP;
                pc_src  = 2'b01;
                pcw_raw = bus.zero;
            end
            S_ADDIWB: rw_raw = 1'b1;
            S_JUMP: begin
                pc_src  = 2'b10;
                pcw_raw = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    // Strobes are masked by rst so an abandoned instruction writes nothing
    assign bus.pc_write    = pcw_raw & ~rst;
    assign bus.ir_write    = irw_raw & ~rst;
    assign bus.mem_read    = mr_raw  & ~rst;
    assign bus.mem_write   = mw_raw  & ~rst;
    assign bus.reg_write   = rw_raw  & ~rst;
    assign bus.iord        = iord;
    assign bus.mem2reg     = m2r;
    assign bus.reg_dst     = rdst;
    assign bus.ex_top      = 1'b1;
    assign bus.alu_src_a   = src_a;
    assign bus.alu_src_b   = src_b;
    assign bus.alu_op      = alu_op;
    assign bus.pc_src      = pc_src;
    assign bus.trap        = trap;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the MIPS datapath over multiple clock cycles (fetch, decode, execute, memory, write-back), so one ALU and one unified memory port can be reused across the phases of each instruction. It sits beside the datapath in place of the single-cycle `ControlUnit`. It consumes the latched opcode/func fields and the ALU zero flag, and drives every datapath mux select and write strobe. It also keeps a retired-instruction counter and traps on unsupported encodings.

## Interface
- `ADD_OP`, 4'b0010: ALU control code for add.
- `SUB_OP`, 4'b0110: ALU control code for subtract.
- `AND_OP`, 4'b0000: ALU control code for AND.
- `OR_OP`, 4'b0001: ALU control code for OR.
- `SLT_OP`, 4'b0111: ALU control code for set-less-than.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction register bits [31:26].
- `func`  in  6  instruction register bits [5:0].
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  PC load enable.
- `ir_write`  out  1  instruction register load enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `mem2reg`  out  1  write-back data select: 1 = memory data, 0 = ALU result.
- `reg_dst`  out  1  destination register select: 1 = rd, 0 = rt.
- `reg_write`  out  1  register bank write enable.
- `ex_top`  out  1  extension select: 1 = sign-extend, 0 = zero-extend.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = RD1.
- `alu_src_b`  out  2  ALU B select: 00 = RD2, 01 = constant 4, 10 = extended immediate, 11 = extended immediate shifted left by 2.
- `alu_op`  out  4  ALU control code.
- `pc_src`  out  2  next-PC select: 00 = ALU output, 01 = ALU result register (branch target), 10 = jump target.
- `trap`  out  1  high while in TRAP.
- `state`  out  4  current state encoding, for debug.
- `instr_count`  out  32  retired-instruction counter.

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
- EXEC = 6, RTWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, TRAP = 15.

State actions and transitions. Any output not listed is 0; `ex_top` = 1 in every state.
- FETCH: `mem_read`=1, `ir_write`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00, `pc_write`=1. Next state: DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (precomputes the branch target). Next state by opcode:
  - 6'h00: EXEC if `func` ∈ {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt}, else TRAP.
  - 6'h23 (lw) or 6'h2B (sw): MEMADR.
  - 6'h04 (beq): BRANCH.
  - 6'h08 (addi): ADDIEX.
  - 6'h02 (j): JUMP.
  - any other opcode: TRAP.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: `mem_read`=1, `iord`=1. Next: MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem2reg`=1. Next: FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Next: FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op` decoded from `func` (add→ADD, sub→SUB, and→AND, or→OR, slt→SLT). Next: RTWB.
- RTWB: `reg_write`=1, `reg_dst`=1, `mem2reg`=0. Next: FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_src`=01, `pc_write`=`zero` (combinational). Next: FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. Next: ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem2reg`=0. Next: FETCH.
- JUMP: `pc_src`=10, `pc_write`=1. Next: FETCH.
- TRAP: all strobes 0, `trap`=1. Stays in TRAP until `rst`.

Other behaviour:
- Unused encodings 12–14 return to FETCH on the next edge.
- `opcode` and `func` are sampled only in DECODE, MEMADR and EXEC. The IR is stable from DECODE onward.
- `instr_count` increments by 1 on each edge that leaves MEMWB, MEMWR, RTWB, BRANCH, ADDIWB or JUMP for FETCH.
  - It wraps from 0xFFFFFFFF to 0.
  - It does not increment on a trap.

## Timing
- Reset: `rst` high asynchronously forces `state`=FETCH and `instr_count`=0. While `rst` is high, `pc_write`, `ir_write`, `mem_read`, `mem_write` and `reg_write` are forced to 0. All other outputs take their FETCH values.
- First fetch: the first FETCH action happens on the first rising edge after `rst` falls.
- Cycles per instruction, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- All outputs except BRANCH `pc_write` are pure functions of `state`, so they change only after clock edges.
- Reset mid-instruction: the instruction is abandoned. No strobe is issued after `rst` rises, and the counter clears.

## Test plan
- Reset: hold `rst` 3 cycles, then release → `state`=0, `instr_count`=0, all strobes 0 during reset. On the first edge, `ir_write`=`pc_write`=1, then `state`=1.
- lw (opcode 0x23) → state sequence 0,1,2,3,4,0. `mem_read`=1 with `iord`=1 in state 3. `reg_write`=1 with `mem2reg`=1 in state 4. `instr_count`=1.
- sw then addi → sw visits 0,1,2,5,0 with one `mem_write` pulse. addi visits 0,1,9,10,0 with `reg_dst`=0. `instr_count`=2.
- beq (0x04):
  - `zero`=1 in BRANCH → `pc_write`=1, `pc_src`=01.
  - `zero`=0 → `pc_write`=0.
  - Both cases take 3 cycles.
- R-type:
  - func 0x22 → `alu_op`=0110 in EXEC.
  - func 0x2A → 0111.
  - func 0x01 → TRAP; `trap` stays 1 for 10 cycles with no strobes and `instr_count` unchanged. `rst` recovers to state 0.
- Assert `rst` in MEMRD → strobes drop immediately, `state`=0, counter=0.
- Preload `instr_count` to 0xFFFFFFFF via a force, then retire j (0x02) → counter 0.
